mem_pattern_engine: RTL and testbench
=====================================

# mem_pattern_engine

Parametrised memory pattern writer/checker for bring-up of on-chip RAM and VRAM. Generalises the fixed screen-fill debugger: programmable base, length, word width and four data patterns, plus an optional read-back verify pass with error counting. It sits in place of the CPU as a bus master, driving the same address/data/request/write strobes into the glue logic.

## Interface
- ADDR_W, 16: bus address width.
- DATA_W, 8: data width; only 8 or 16 are legal.
- LEN_W, 10: width of the transfer length field.
- RD_LAT, 1: read latency of the target memory, in clocks; legal values are 1 to 4.

- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a run; ignored while busy=1.
- mode  in  2  pattern select: 0 counter, 1 constant, 2 walking-one, 3 LFSR.
- base_addr  in  ADDR_W  first address of the run.
- length  in  LEN_W  number of words in the run.
- fill_value  in  DATA_W  seed, constant or start value, depending on mode.
- mem_addr  out  ADDR_W  bus address.
- mem_data_out  out  DATA_W  write data.
- mem_data_in  in  DATA_W  read data; valid RD_LAT clocks after the read is issued.
- mem_req_n  out  1  bus request, active low.
- mem_write_n  out  1  write strobe, active low.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- pass  out  1  run result; held until the next accepted start.
- err_count  out  LEN_W  number of miscompares in the last run.
- err_addr  out  ADDR_W  address of the first miscompare in the last run.

## Operation
- mode, base_addr, length and fill_value are latched when start is accepted; later input changes have no effect on the run.
- Word index i runs from 0 to length-1. Address is (base_addr+i) mod 2^ADDR_W; wrap past the top of the address space is silent.
- Patterns, all truncated to DATA_W:
  - mode 0 (counter): fill_value+i.
  - mode 1 (constant): fill_value.
  - mode 2 (walking-one): 1 << (i mod DATA_W).
  - mode 3 (LFSR): Galois LFSR seeded with fill_value, with seed 0 replaced by 1. It advances once per word. Taps are 0xB8 for DATA_W=8 and 0xB400 for DATA_W=16.
- FSM states and transitions:
  - IDLE → WRITE on an accepted start with length≠0.
  - IDLE → DONE on an accepted start with length=0.
  - WRITE issues one write per cycle. After word length-1 it goes to GAP, or to DONE if verify is compiled out.
  - GAP is one bus-idle cycle, then VERIFY.
  - VERIFY issues one read per cycle, restarting the pattern generator from index 0. After the last read it goes to DRAIN.
  - DRAIN waits RD_LAT cycles, then DONE.
  - DONE pulses done for one cycle, then IDLE.
- Compare:
  - Expected data is delayed RD_LAT stages alongside a valid bit and the address.
  - On a valid sample with mem_data_in≠expected, err_count increments.
  - err_addr is captured only on the first miscompare of a run.
  - err_count cannot overflow, because length ≤ 2^LEN_W-1.
- err_count and err_addr clear on an accepted start. pass is set in DONE to (err_count==0).
- Outside WRITE and VERIFY: mem_req_n=1, mem_write_n=1, mem_addr=0. mem_data_out holds its last value.
- Reset mid-run aborts immediately. The bus is released and no done pulse is produced.
- Reset values: mem_addr=0, mem_data_out=0, mem_req_n=1, mem_write_n=1, busy=0, done=0, pass=0, err_count=0, err_addr=0. The FSM resets to IDLE.

## Timing
All bus outputs are registered. In the timing below, start is sampled high at edge T and N=length.
- busy rises at T+1 and falls in the same cycle done rises.
- Write i: mem_req_n=0, mem_write_n=0, address and data valid in cycle T+1+i.
- GAP occupies cycle T+N+1.
- Read j: mem_req_n=0, mem_write_n=1 in cycle T+N+2+j. Its data is sampled at T+N+2+j+RD_LAT.
- done is high in cycle T+2N+2+RD_LAT, with verify compiled in.
- done is high in cycle T+N+1, with verify compiled out.
- done is high in cycle T+1 for length=0, with no bus activity.
- start arriving in the cycle done is high is ignored. start is first accepted the cycle after done.

## Configuration
- PATTERN_VERIFY_EN:
  - When defined, the GAP, VERIFY and DRAIN states, the compare pipeline, err_count and err_addr are compiled in.
  - When undefined, the run is write-only. err_count and err_addr are tied to 0, pass=1 at DONE, and mem_data_in is unused.

## Test plan
- Counter fill into a 1 KB RAM model, RD_LAT=1: base 0x3C00, length 1024, fill 0x00 → 1024 writes of 0x00..0xFF repeating. done at T+2051, pass=1, err_count=0.
- Walking-one, DATA_W=8: base 0x0010, length 10 → written data 01,02,04,…,80,01,02 at 0x0010..0x0019.
- LFSR, seed 0: first four words are 0x01, 0xB8, 0x5C, 0x2E. Verify pass passes.
- Fault injection: the RAM model forces bit 3 at address 0x3C05 and 0x3C07 stuck at 0 during a constant 0xFF fill → err_count=2, err_addr=0x3C05, pass=0.
- Wrap and edge cases:
  - base 0xFFFE, length 4 → addresses FFFE, FFFF, 0000, 0001.
  - length 0 → done at T+1, no mem_req_n low.
  - start while busy=1 → ignored.
- Reset: reset_n low during write 5 → all outputs return to reset values immediately, with no done pulse. A new start after reset runs normally.

Source files
------------

// File: rtl/mem_pattern_engine.sv
// mem_pattern_engine: bus-master RAM pattern writer with an optional read-back verify pass.
// Define PATTERN_VERIFY_EN to compile in the verify pass, compare pipeline and error counters.
module mem_pattern_engine #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 10,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic [DATA_W-1:0] fill_value,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_out,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              mem_req_n,
   output logic              mem_write_n,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [LEN_W-1:0]  err_count,
   output logic [ADDR_W-1:0] err_addr
);
   localparam logic [DATA_W-1:0] TAPS = (DATA_W == 16) ? DATA_W'(16'hB400) : DATA_W'(8'hB8);
   typedef enum logic [2:0] {IDLE, WRITE, GAP, VERIFY, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [1:0]        l_mode;
   logic [ADDR_W-1:0] l_base;
   logic [LEN_W-1:0]  l_len, cnt;
   logic [DATA_W-1:0] l_fill, pat, pat_nx;
   logic              accept, last, issue, first, clean;

   function automatic logic [DATA_W-1:0] first_pat(input logic [1:0] m, input logic [DATA_W-1:0] f);
      return (m == 2'd2 || (m == 2'd3 && f == '0)) ? DATA_W'(1) : f;
   endfunction

   function automatic logic [DATA_W-1:0] step_pat(input logic [1:0] m, input logic [DATA_W-1:0] p);
      return m == 2'd0 ? p + 1'b1 :
             m == 2'd1 ? p :
             m == 2'd2 ? {p[DATA_W-2:0], p[DATA_W-1]} :
             (p >> 1) ^ (p[0] ? TAPS : '0);
   endfunction

   assign accept = start && state == IDLE;
   assign last   = cnt == l_len;
   assign issue  = state_nx == WRITE || state_nx == VERIFY;
   assign first  = state_nx != state;
   assign busy   = state != IDLE && state != DONE;
   assign done   = state == DONE;
   // Entering WRITE/VERIFY reloads the generator; otherwise it steps once per issued word.
   assign pat_nx = first ? first_pat(accept ? mode : l_mode, accept ? fill_value : l_fill)
                         : step_pat(l_mode, pat);

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (length == '0) ? DONE : WRITE;
`ifdef PATTERN_VERIFY_EN
         WRITE:   if (last) state_nx = GAP;
         GAP:     state_nx = VERIFY;
         VERIFY:  if (last) state_nx = DRAIN;
         DRAIN:   if (cnt == LEN_W'(RD_LAT - 1)) state_nx = DONE;
`else
         WRITE:   if (last) state_nx = DONE;
`endif
         default: state_nx = IDLE;
      endcase
   end

   // cnt counts words issued in WRITE/VERIFY, and elapsed cycles in DRAIN.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         l_mode       <= '0;
         l_base       <= '0;
         l_len        <= '0;
         l_fill       <= '0;
         cnt          <= '0;
         pat          <= '0;
         mem_addr     <= '0;
         mem_data_out <= '0;
         mem_req_n    <= 1'b1;
         mem_write_n  <= 1'b1;
         pass         <= 1'b0;
      end else begin
         if (accept) begin
            l_mode <= mode;
            l_base <= base_addr;
            l_len  <= length;
            l_fill <= fill_value;
         end
         cnt         <= first ? LEN_W'(issue) : cnt + 1'b1;
         mem_req_n   <= !issue;
         mem_write_n <= state_nx != WRITE;
         mem_addr    <= !issue ? '0 : first ? (accept ? base_addr : l_base) : mem_addr + 1'b1;
         if (issue) pat <= pat_nx;
         if (state_nx == WRITE) mem_data_out <= pat_nx;
         pass <= accept ? length == '0 : (state_nx == DONE && state != DONE) ? clean : pass;
      end

`ifdef PATTERN_VERIFY_EN
   logic [RD_LAT-1:0] pv;
   logic [DATA_W-1:0] pe [RD_LAT];
   logic [ADDR_W-1:0] pa [RD_LAT];
   logic              miss;

   assign miss  = pv[RD_LAT-1] && mem_data_in != pe[RD_LAT-1];
   assign clean = err_count == '0 && !miss;

   always_ff @(posedge clk) begin
      pe[0] <= pat;
      pa[0] <= mem_addr;
      for (int k = 1; k < RD_LAT; k++) begin
         pe[k] <= pe[k-1];
         pa[k] <= pa[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pv        <= '0;
         err_count <= '0;
         err_addr  <= '0;
      end else begin
         pv        <= (pv << 1) | RD_LAT'(state == VERIFY);
         err_count <= accept ? '0 : err_count + LEN_W'(miss);
         err_addr  <= accept ? '0 : (miss && err_count == '0) ? pa[RD_LAT-1] : err_addr;
      end
`else
   localparam int unused_lat = RD_LAT;
   logic unused_in;
   assign unused_in = ^mem_data_in;
   assign clean     = 1'b1;
   assign err_count = '0;
   assign err_addr  = '0;
`endif
endmodule

// File: tb/tb_mem_pattern_engine.sv
// tb_mem_pattern_engine: scoreboard bench; stimulus queues expected writes and results, a monitor pops and compares.
module tb_mem_pattern_engine;
`ifdef PATTERN_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  mode = '0;
   logic [15:0] base_addr = '0;
   logic [10:0] length = '0;
   logic [7:0]  fill_value = '0;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data_out, mem_data_in;
   logic        mem_req_n, mem_write_n, busy, done, pass;
   logic [10:0] err_count;
   logic [15:0] err_addr;

   mem_pattern_engine #(.ADDR_W(16), .DATA_W(8), .LEN_W(11), .RD_LAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .base_addr(base_addr),
      .length(length), .fill_value(fill_value), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
      .mem_data_in(mem_data_in), .mem_req_n(mem_req_n), .mem_write_n(mem_write_n), .busy(busy),
      .done(done), .pass(pass), .err_count(err_count), .err_addr(err_addr));

   always #5 clk = ~clk;

   typedef struct {
      longint      cyc;
      logic        p;
      logic [10:0] ec;
      logic [15:0] ea;
   } res_t;

   logic [23:0] wq [$];
   res_t        rq [$];
   longint      cyc = 0;
   int          checks = 0, errors = 0;
   logic [7:0]  mem [0:65535];
   logic        fault_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model with one-cycle read latency; fault_en sticks bit 3 low at two addresses on read
   always @(posedge clk) begin
      logic [7:0] d;
      if (!mem_req_n && !mem_write_n) mem[mem_addr] <= mem_data_out;
      d = mem[mem_addr];
      if (fault_en && (mem_addr == 16'h3C05 || mem_addr == 16'h3C07)) d[3] = 1'b0;
      if (!mem_req_n && mem_write_n) mem_data_in <= d;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (!mem_req_n && !mem_write_n) begin
            if (wq.size() == 0) check("unexpected_write", {mem_addr, mem_data_out}, 64'hFFFF_FFFF);
            else check("write_addr_data", {mem_addr, mem_data_out}, wq.pop_front());
         end
         if (done) begin
            if (rq.size() == 0) check("unexpected_done", 1, 0);
            else begin
               res_t r;
               r = rq.pop_front();
               check("done_cycle", cyc, r.cyc);
               check("pass", pass, r.p);
               check("err_count", err_count, r.ec);
               check("err_addr", err_addr, r.ea);
               check("busy_at_done", busy, 0);
            end
         end
      end
   end

   task automatic go(input logic [1:0] m, input logic [15:0] b, input logic [10:0] n, input logic [7:0] f,
                     input logic ep, input logic [10:0] eec, input logic [15:0] eea, input bit poke);
      longint t;
      res_t   r;
      bit     ok = 0;
      @(negedge clk);
      t = cyc;
      mode = m; base_addr = b; length = n; fill_value = f; start = 1'b1;
      r.cyc = t + ((n == 0) ? 1 : VER ? 2 * n + 3 : n + 1);
      r.p = ep; r.ec = eec; r.ea = eea;
      rq.push_back(r);
      @(negedge clk);
      start = 1'b0;
      mode = ~m; base_addr = 16'hA5A5; length = 11'd7; fill_value = 8'h3C;
      if (n != 0) check("busy_rise", busy, 1);
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (poke && (cyc == t + 3 || done)) begin
            start = 1'b1; mode = 2'd1; base_addr = 16'h5000; length = 11'd3; fill_value = 8'hAA;
         end else start = 1'b0;
         if (rq.size() == 0 && !done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check("run_timeout", 0, 1);
         wq.delete();
         rq.delete();
      end
   endtask

   initial begin
      logic [7:0] lf [6];
      repeat (2) @(negedge clk);
      check("rst_req_n", mem_req_n, 1);
      check("rst_write_n", mem_write_n, 1);
      check("rst_busy_done_pass", {busy, done, pass}, 0);
      check("rst_addr_data", {mem_addr, mem_data_out}, 0);
      reset_n = 1'b1;
      // counter fill over 1 KB window
      for (int i = 0; i < 1024; i++) wq.push_back({16'(16'h3C00 + i), 8'(i)});
      go(2'd0, 16'h3C00, 11'd1024, 8'h00, 1'b1, 0, 0, 0);
      // walking-one, fill value ignored
      for (int i = 0; i < 10; i++) wq.push_back({16'(16'h0010 + i), 8'(1 << (i % 8))});
      go(2'd2, 16'h0010, 11'd10, 8'h55, 1'b1, 0, 0, 0);
      // LFSR seeded with 0
      lf = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
      for (int i = 0; i < 6; i++) wq.push_back({16'(16'h0200 + i), lf[i]});
      go(2'd3, 16'h0200, 11'd6, 8'h00, 1'b1, 0, 0, 0);
      // constant fill with stuck bits
      fault_en = 1'b1;
      for (int i = 0; i < 16; i++) wq.push_back({16'(16'h3C00 + i), 8'hFF});
      go(2'd1, 16'h3C00, 11'd16, 8'hFF, !VER, VER ? 11'd2 : 11'd0, VER ? 16'h3C05 : 16'h0, 0);
      fault_en = 1'b0;
      // address wrap
      wq.push_back({16'hFFFE, 8'h40});
      wq.push_back({16'hFFFF, 8'h41});
      wq.push_back({16'h0000, 8'h42});
      wq.push_back({16'h0001, 8'h43});
      go(2'd0, 16'hFFFE, 11'd4, 8'h40, 1'b1, 0, 0, 0);
      // zero length
      go(2'd0, 16'h0300, 11'd0, 8'h11, 1'b1, 0, 0, 0);
      // starts while busy and during done are ignored
      for (int i = 0; i < 8; i++) wq.push_back({16'(16'h2000 + i), 8'h33});
      go(2'd1, 16'h2000, 11'd8, 8'h33, 1'b1, 0, 0, 1);
      // reset during write 5
      for (int i = 0; i < 6; i++) wq.push_back({16'(16'h1000 + i), 8'h77});
      @(negedge clk);
      begin
         longint t;
         t = cyc;
         mode = 2'd1; base_addr = 16'h1000; length = 11'd20; fill_value = 8'h77; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         while (cyc < t + 6) @(negedge clk);
      end
      #1 reset_n = 1'b0;
      #1;
      check("abort_req_write_n", {mem_req_n, mem_write_n}, 2'b11);
      check("abort_addr_data", {mem_addr, mem_data_out}, 0);
      check("abort_busy_done_pass", {busy, done, pass}, 0);
      check("abort_err", {err_count, err_addr}, 0);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      reset_n = 1'b1;
      check("abort_writes_seen", wq.size(), 0);
      for (int i = 0; i < 3; i++) wq.push_back({16'(16'h0100 + i), 8'(1 << i)});
      go(2'd2, 16'h0100, 11'd3, 8'h00, 1'b1, 0, 0, 0);
      repeat (5) @(negedge clk);
      check("write_queue_empty", wq.size(), 0);
      check("result_queue_empty", rq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
